// File: rtl/ctrlpid_mc.sv
// Multi-channel PID controller. A single datapath is time-shared across 2^AW channels.
// A free-running counter selects the channel and the step within that channel's slot.
module ctrlpid_mc #(
  parameter int PSC       = 15,
  parameter int AW        = 2,
  parameter int OW        = 12,
  parameter int EW        = 24,
  parameter int PW        = 32,
  parameter int CW        = 6,
  parameter int FP        = 9,
  parameter int PRECISION = 1,
  localparam int AN       = 1 << AW
) (
  input  logic          clk_pid,
  input  logic          reset,
  input  logic [EW-1:0] error,
  input  logic [CW-1:0] KP,
  input  logic [CW-1:0] KI,
  input  logic [CW-1:0] KD,
  input  logic [PW-1:0] clamp,
  input  logic [AN-1:0] ch_en,
  input  logic [AN-1:0] clr,
  output logic [AW-1:0] a,
  output logic          ce,
  output logic [OW-1:0] m_k_out,
  output logic          sat
);

  // state | meaning
  // 0     | settle: inputs follow the new channel address
  // 1     | load error into e0, or clear the channel
  // 2     | proportional term
  // 3     | derivative term (e0, e2)
  // 4     | integral term (trapezoid on e0, e1)
  // 5     | derivative correction on e1
  // 6     | clip u to +/-L and update sat
  // 7     | register the channel output
  // 8     | age the error history, raise ce
  // 15    | drop ce (runs even for disabled channels)
  typedef enum logic [3:0] {
    ST_SETTLE = 4'd0,
    ST_LOAD   = 4'd1,
    ST_P      = 4'd2,
    ST_D      = 4'd3,
    ST_I      = 4'd4,
    ST_D2     = 4'd5,
    ST_CLIP   = 4'd6,
    ST_OUT    = 4'd7,
    ST_SHIFT  = 4'd8,
    ST_END    = 4'd15
  } step_e;

  localparam int SW = CW + 3;
  localparam int XW = 2 * PW;
  localparam logic signed [SW-1:0] OFF_P  = SW'(PRECISION);
  localparam logic signed [SW-1:0] OFF_D  = SW'(PRECISION + FP);
  localparam logic signed [SW-1:0] OFF_I  = SW'(PRECISION - 1 - FP);
  localparam logic signed [SW-1:0] OFF_D2 = SW'(PRECISION + 1 + FP);
  localparam logic signed [PW-1:0] S_MAX  = {1'b0, {(PW-1){1'b1}}};
  localparam logic signed [PW-1:0] S_MIN  = {1'b1, {(PW-1){1'b0}}};
  localparam logic [PW-1:0]        DEF_LIM = PW'(255) << (PRECISION + OW - 9);

  logic [PSC-1:0]        uswitch;
  logic                  ce_q;
  logic [AN-1:0]         sat_q;
  logic signed [PW-1:0]  e0_q [AN];
  logic signed [PW-1:0]  e1_q [AN];
  logic signed [PW-1:0]  e2_q [AN];
  logic signed [PW-1:0]  u_q  [AN];
  logic [OW-1:0]         out_q [AN];

  step_e step;
  logic  tick;
  logic  run;

  assign a    = uswitch[PSC-1 -: AW];
  assign step = step_e'(uswitch[PSC-AW-1 -: 4]);
  assign tick = (uswitch[PSC-AW-5:0] == '0);
  assign run  = tick && (ch_en[a] || step == ST_END);

  assign ce      = ce_q;
  assign m_k_out = out_q[a];
  assign sat     = sat_q[a];

  // Shift is evaluated at double width so that left shifts saturate instead of wrapping.
  function automatic logic signed [PW-1:0] sh(input logic signed [PW-1:0] x,
                                              input logic signed [SW-1:0] s);
    logic signed [XW-1:0] wide;
    logic [SW-1:0]        mag;
    mag = s[SW-1] ? SW'(-s) : SW'(s);
    if (mag > SW'(PW-1)) mag = SW'(PW-1);
    wide = {{PW{x[PW-1]}}, x};
    if (s[SW-1]) wide = wide >>> mag;
    else         wide = wide <<< mag;
    if ((&wide[XW-1:PW-1]) || !(|wide[XW-1:PW-1])) sh = wide[PW-1:0];
    else sh = wide[XW-1] ? S_MIN : S_MAX;
  endfunction

  function automatic logic signed [PW-1:0] sat_pw(input logic signed [PW+1:0] v);
    if ((&v[PW+1:PW-1]) || !(|v[PW+1:PW-1])) sat_pw = v[PW-1:0];
    else sat_pw = v[PW+1] ? S_MIN : S_MAX;
  endfunction

  logic signed [SW-1:0]  kp_x, ki_x, kd_x, s_sel;
  logic signed [PW-1:0]  x_a, x_b, t_a, t_b, u_sel, u_next;
  logic signed [PW+1:0]  sum;
  logic                  sub_b;
  logic [PW-1:0]         lim;
  logic signed [PW:0]    u_e, l_e, neg_l;
  logic                  over, under;
  logic signed [PW-1:0]  err_x;

  always_comb begin
    kp_x  = {{3{KP[CW-1]}}, KP};
    ki_x  = {{3{KI[CW-1]}}, KI};
    kd_x  = {{3{KD[CW-1]}}, KD};
    err_x = {{(PW-EW){error[EW-1]}}, error};
    u_sel = u_q[a];
    x_a   = '0;
    x_b   = '0;
    s_sel = '0;
    sub_b = 1'b0;
    case (step)
      ST_P: begin
        x_a = e0_q[a]; x_b = e1_q[a]; s_sel = kp_x + OFF_P; sub_b = 1'b1;
      end
      ST_D: begin
        x_a = e0_q[a]; x_b = e2_q[a]; s_sel = kd_x + OFF_D;
      end
      ST_I: begin
        x_a = e0_q[a]; x_b = e1_q[a]; s_sel = ki_x + OFF_I;
      end
      ST_D2: begin
        x_b = e1_q[a]; s_sel = kd_x + OFF_D2; sub_b = 1'b1;
      end
      default: ;
    endcase
    t_a = sh(x_a, s_sel);
    t_b = sh(x_b, s_sel);
    if (sub_b) sum = {{2{u_sel[PW-1]}}, u_sel} + {{2{t_a[PW-1]}}, t_a} - {{2{t_b[PW-1]}}, t_b};
    else       sum = {{2{u_sel[PW-1]}}, u_sel} + {{2{t_a[PW-1]}}, t_a} + {{2{t_b[PW-1]}}, t_b};
    u_next = sat_pw(sum);

    // Limit compare is one bit wider so a large unsigned clamp cannot alias negative.
    lim   = (clamp != '0) ? clamp : DEF_LIM;
    u_e   = {u_sel[PW-1], u_sel};
    l_e   = {1'b0, lim};
    neg_l = -l_e;
    over  = (u_e > l_e);
    under = (u_e < neg_l);
  end

  always_ff @(posedge clk_pid or negedge reset) begin
    if (!reset) begin
      uswitch <= '0;
      ce_q    <= 1'b0;
      sat_q   <= '0;
      for (int i = 0; i < AN; i++) begin
        e0_q[i]  <= '0;
        e1_q[i]  <= '0;
        e2_q[i]  <= '0;
        u_q[i]   <= '0;
        out_q[i] <= '0;
      end
    end else begin
      uswitch <= uswitch + PSC'(1);
      if (run) begin
        case (step)
          ST_LOAD: begin
            if (clr[a]) begin
              e0_q[a] <= '0;
              e1_q[a] <= '0;
              e2_q[a] <= '0;
              u_q[a]  <= '0;
            end else begin
              e0_q[a] <= err_x;
            end
          end
          ST_P, ST_D, ST_I, ST_D2: u_q[a] <= u_next;
          ST_CLIP: begin
            if (over) begin
              u_q[a]   <= lim;
              sat_q[a] <= 1'b1;
            end else if (under) begin
              u_q[a]   <= neg_l[PW-1:0];
              sat_q[a] <= 1'b1;
            end else begin
              sat_q[a] <= 1'b0;
            end
          end
          ST_OUT: out_q[a] <= u_q[a][PRECISION+OW-1:PRECISION];
          ST_SHIFT: begin
            e2_q[a] <= e1_q[a];
            e1_q[a] <= e0_q[a];
            ce_q    <= 1'b1;
          end
          ST_END: ce_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/ctrlpid_mc.md
CTRLPID_MC -- requirements
Module: ctrlpid_mc

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- PSC, 15, prescaler bits; legal range PSC >= AW+5.
- AW, 2, channel address bits; AN = 2^AW channels.
- OW, 12, output width.
- EW, 24, error width; EW < PW.
- PW, 32, accumulator width.
- CW, 6, gain width.
- FP, 9, log2 loop-rate constant.
- PRECISION, 1, fixed-point fraction bits; PRECISION+OW <= PW.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_pid, in, 1, sole clock.
- reset, in, 1, asynchronous, active-low.
- error, in, EW, signed error of channel a.
- KP / KI / KD, in, CW each, signed log2 gains of channel a.
- clamp, in, PW, unsigned runtime output limit; 0 selects the default limit.
- ch_en, in, AN, per-channel enable.
- clr, in, AN, per-channel clear request.
- a, out, AW, current channel address.
- ce, out, 1, output data valid.
- m_k_out, out, OW, signed output of channel a.
- sat, out, 1, channel a was clipped at its last update.

Function
REQ-003 Free-running counter uswitch[PSC-1:0]: a = uswitch[PSC-1:PSC-AW]; state = uswitch[PSC-AW-1:PSC-AW-4]; a step executes only when uswitch[PSC-AW-5:0] == 0.
REQ-004 Steps are skipped when ch_en[a] = 0, except that state 15 always executes.
REQ-005 State 0: no operation (inputs settle after the address change).
REQ-006 State 1: if clr[a] = 1, zero e0, e1, e2 and u of channel a; otherwise e0 <= sign-extended error.
REQ-007 Effective shifts are computed in CW+3 signed bits with no wrap:
- sp = KP+PRECISION
- sd = KD+PRECISION+FP
- si = KI+PRECISION-1-FP
- sd2 = KD+PRECISION+1+FP
REQ-008 A shift s >= 0 is an arithmetic left shift; s < 0 is an arithmetic right shift by -s; |s| saturates at PW-1.
REQ-009 State 2: u += (e0<<sp) - (e1<<sp).
REQ-010 State 3: u += sh(e0,sd) + sh(e2,sd).
REQ-011 State 4: u += sh(e0,si) + sh(e1,si).
REQ-012 State 5: u -= sh(e1,sd2).
REQ-013 Sums in REQ-009..012 are computed at PW+2 bits and saturate to the PW signed range (never wrap).
REQ-014 Limit L = clamp when clamp != 0, otherwise 255 << (PRECISION+OW-9).
REQ-015 State 6: if u > L then u <= L and sat[a] <= 1; if u < -L then u <= -L and sat[a] <= 1; otherwise sat[a] <= 0.
REQ-016 State 7: out[a] <= u[PRECISION+OW-1:PRECISION] (registered per channel).
REQ-017 State 8: e2 <= e1, e1 <= e0, ce <= 1.
REQ-018 State 15: ce <= 0.
REQ-019 ce is high from the state-8 step through the state-15 step of an enabled channel, and is never raised by a disabled channel.
REQ-020 m_k_out = out[a] and sat = sat[a]; both are combinational mux outputs of registers.
REQ-021 A disabled channel holds all of its registers.
REQ-022 Re-enabling a channel resumes from its held state at the next state-0.
REQ-023 clr sampled outside the state-1 step has no effect.
REQ-024 ch_en or clr changing mid-slot takes effect at the next executed step only.
REQ-025 Gains and clamp are sampled at each step that uses them.

Reset
REQ-026 While reset = 0, uswitch, ce, every e0/e1/e2/u/out entry and every sat bit are 0; a = 0, m_k_out = 0, sat = 0.
REQ-027 Assertion takes effect asynchronously, including mid-slot; deassertion restarts from state 0 of channel 0 on the next clock edge.

Verification (PSC=9, AW=2, defaults otherwise)
REQ-028 Reset mid-slot: u nonzero, reset pulsed -> all outputs 0 immediately; the first step after release is channel 0, state 0.
REQ-029 P only: KP=0, KI=KD=-31, error=100 -> after slot 1, m_k_out=100 and ce high for states 8..15; with error held, it stays 100.
REQ-030 Antiwindup: clamp=1000, KI=5, error=50000 -> u pinned at 1000, m_k_out=500, sat=1; with error=-50000 -> m_k_out=-500, sat=1.
REQ-031 Overflow: KP=31, error=0x7FFFFF -> u saturates, never wraps sign; with clamp=0, m_k_out=2040, sat=1.
REQ-032 Channel isolation: ch_en=4'b1011 -> channel 2 never raises ce and holds out; clr[1] pulsed during its state 1 -> channel 1 u=0, m_k_out=0 at state 7.
